hazard_stall_controller: RTL and testbench
==========================================

// Module: hazard_stall_controller
// PURPOSE
//  Pipeline hazard/stall controller for the 5-stage RISC-V core: the parametrised successor of the
//  single-cycle load-use detector. It detects load-use hazards (x0 excluded), holds the stall for a
//  configurable load-to-use latency, flushes on taken branches, freezes the pipe while data memory
//  is busy, and counts stall cycles. Sits beside the IF/ID and ID/EX registers and drives their enables.
// PARAMETERS
//  REG_AW          5   register-address width
//  LOAD_USE_STALLS 1   bubble cycles per load-use hazard (>=1)
//  CNT_W           16  width of the saturating stall-cycle counter
// PORTS
//  clk              in   1        core clock, rising edge
//  rst_n            in   1        asynchronous active-low reset
//  id_ex_mem_read   in   1        instruction in EX is a load
//  id_ex_rd         in   REG_AW   destination register of the instruction in EX
//  if_id_rs1        in   REG_AW   source register 1 of the instruction in ID
//  if_id_rs2        in   REG_AW   source register 2 of the instruction in ID
//  branch_taken     in   1        taken branch/jump resolved in EX this cycle
//  mem_req          in   1        MEM stage has an active data-memory access
//  mem_ready        in   1        data memory completes the access this cycle
//  pc_write         out  1        1 = PC may update
//  if_id_write      out  1        1 = IF/ID register may load
//  id_ex_bubble     out  1        1 = load NOP controls into ID/EX
//  if_id_flush      out  1        1 = clear IF/ID to NOP
//  pipe_freeze      out  1        1 = hold all pipeline registers (incl. EX/MEM, MEM/WB)
//  stall_cnt        out  CNT_W    total cycles with pc_write==0, saturating
// BEHAVIOUR
//  - FSM states: RUN, LOAD_STALL, MEM_WAIT. Reset: state=RUN, remaining=0, stall_cnt=0.
//  - While rst_n low outputs are pc_write=1, if_id_write=1, id_ex_bubble=0, if_id_flush=0,
//    pipe_freeze=0; rst_n may assert at any cycle, including mid-stall; the FSM returns to RUN.
//  - hazard = id_ex_mem_read && id_ex_rd!=0 && (id_ex_rd==if_id_rs1 || id_ex_rd==if_id_rs2).
//  - mem_busy = mem_req && !mem_ready. Outputs are combinational from state and inputs (Mealy).
//  - Priority per cycle: mem_busy > branch_taken > hazard/LOAD_STALL > normal flow.
//  - mem_busy in any state: pipe_freeze=1, pc_write=0, if_id_write=0, id_ex_bubble=0,
//    if_id_flush=0; the FSM records the return state in MEM_WAIT; remaining is held unchanged.
//    When mem_busy clears, the FSM resumes the saved state (RUN or LOAD_STALL) with the same
//    remaining count.
//  - branch_taken (no mem_busy): if_id_flush=1, id_ex_bubble=1, pc_write=1, if_id_write=1;
//    any pending LOAD_STALL is cancelled (remaining:=0, state:=RUN), because the dependent
//    instruction is flushed.
//  - RUN with hazard: pc_write=0, if_id_write=0, id_ex_bubble=1 in the same cycle (stall 1).
//    If LOAD_USE_STALLS>1, go to LOAD_STALL with remaining=LOAD_USE_STALLS-1; else stay in RUN.
//  - LOAD_STALL: same three stall outputs; remaining decrements every non-frozen cycle;
//    the cycle where remaining==1 is the last stall, and the FSM returns to RUN.
//    The hazard input is ignored in LOAD_STALL (ID/EX already holds a bubble).
//  - The total load-use penalty is exactly LOAD_USE_STALLS cycles, excluding frozen cycles.
//  - Without a stall, branch or freeze: pc_write=1, if_id_write=1, all other outputs 0.
//  - stall_cnt increments by 1 on each clock edge where pc_write==0 (stall or freeze).
//    The branch-flush cycle is not counted. At 2^CNT_W-1 stall_cnt holds; it does not wrap.
//  - remaining is $clog2(LOAD_USE_STALLS+1) bits wide. No state is reachable outside the three
//    named states; any illegal encoding recovers to RUN.
// TESTING
//  1 N=1: mem_read=1, rd=5, rs1=5 for one cycle -> 1 cycle with pc_write=0 and id_ex_bubble=1,
//    then normal flow; stall_cnt=1.
//  2 N=3: same hazard -> exactly 3 consecutive stall cycles, then pc_write=1; stall_cnt=3.
//  3 rd=0, rs1=0, mem_read=1 -> no stall. rd=7, rs2=7, mem_read=0 -> no stall.
//  4 N=3: branch_taken on 2nd stall cycle -> that cycle has flush=1, bubble=1, pc_write=1;
//    next cycle is RUN with no further stall.
//    Hazard and branch_taken in the same cycle -> flush only, no stall.
//  5 N=3: mem_req=1, mem_ready=0 for 4 cycles starting at stall cycle 2 -> pipe_freeze=1 for
//    4 cycles, then 2 more stall cycles; stall_cnt=7.
//  6 rst_n low during LOAD_STALL -> outputs at reset values immediately (async), stall_cnt=0.
//    CNT_W=3 with 10 stall cycles -> stall_cnt saturates at 7.

Source files
------------

// File: rtl/hazard_stall_controller.sv
// Load-use / branch-flush / memory-freeze stall controller for the 5-stage core.
// Drives PC, IF/ID and ID/EX enables and keeps a saturating count of stalled cycles.
module hazard_stall_controller #(
    parameter int REG_AW          = 5,
    parameter int LOAD_USE_STALLS = 1,
    parameter int CNT_W           = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_ex_mem_read,
    input  logic [REG_AW-1:0] id_ex_rd,
    input  logic [REG_AW-1:0] if_id_rs1,
    input  logic [REG_AW-1:0] if_id_rs2,
    input  logic              branch_taken,
    input  logic              mem_req,
    input  logic              mem_ready,
    output logic              pc_write,
    output logic              if_id_write,
    output logic              id_ex_bubble,
    output logic              if_id_flush,
    output logic              pipe_freeze,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int               REM_W    = $clog2(LOAD_USE_STALLS + 1);
    localparam logic [REM_W-1:0] REM_INIT = REM_W'(LOAD_USE_STALLS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        MEM_WAIT   = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic             saved_ls, saved_ls_nxt;
    logic [REM_W-1:0] remaining, remaining_nxt;
    logic             hazard;
    logic             mem_busy;
    logic             eff_ls;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    assign hazard = id_ex_mem_read && (id_ex_rd != '0) &&
                    ((id_ex_rd == if_id_rs1) || (id_ex_rd == if_id_rs2));
    assign mem_busy = mem_req && !mem_ready;

    always_comb begin
        state_nxt     = state;
        saved_ls_nxt  = saved_ls;
        remaining_nxt = remaining;
        pc_write      = 1'b1;
        if_id_write   = 1'b1;
        id_ex_bubble  = 1'b0;
        if_id_flush   = 1'b0;
        pipe_freeze   = 1'b0;
        eff_ls        = 1'b0;

        // MEM_WAIT behaves as the state it interrupted once memory is ready.
        case (state)
            LOAD_STALL: eff_ls = 1'b1;
            MEM_WAIT:   eff_ls = saved_ls;
            default:    eff_ls = 1'b0;
        endcase

        if (mem_busy) begin
            pipe_freeze  = 1'b1;
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            state_nxt    = MEM_WAIT;
            saved_ls_nxt = eff_ls;
        end else if (branch_taken) begin
            if_id_flush   = 1'b1;
            id_ex_bubble  = 1'b1;
            state_nxt     = RUN;
            remaining_nxt = '0;
        end else if (eff_ls) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
            if (remaining <= REM_W'(1)) begin
                state_nxt     = RUN;
                remaining_nxt = '0;
            end else begin
                state_nxt     = LOAD_STALL;
                remaining_nxt = remaining - REM_W'(1);
            end
        end else begin
            state_nxt = RUN;
            if (hazard) begin
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                id_ex_bubble = 1'b1;
                if (LOAD_USE_STALLS > 1) begin
                    state_nxt     = LOAD_STALL;
                    remaining_nxt = REM_INIT;
                end
            end
        end

        // Outputs take their free-running values for as long as reset is held.
        if (!rst_n) begin
            pc_write     = 1'b1;
            if_id_write  = 1'b1;
            id_ex_bubble = 1'b0;
            if_id_flush  = 1'b0;
            pipe_freeze  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            saved_ls  <= 1'b0;
            remaining <= '0;
            stall_cnt <= '0;
        end else begin
            state     <= state_nxt;
            saved_ls  <= saved_ls_nxt;
            remaining <= remaining_nxt;
            if (!pc_write)
                stall_cnt <= sat_inc(stall_cnt);
        end
    end

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Bench for hazard_stall_controller: three instances (N=1, N=3, narrow counter) on shared
// inputs; a table of vectors feeds a scoreboard that is checked at the falling edge.
module tb_hazard_stall_controller;

    localparam logic [4:0] NORM  = 5'b11000;  // {pc_write, if_id_write, bubble, flush, freeze}
    localparam logic [4:0] STALL = 5'b00100;
    localparam logic [4:0] FLUSH = 5'b11110;
    localparam logic [4:0] FRZ   = 5'b00001;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       mr = 1'b0, br = 1'b0, mreq = 1'b0, mrdy = 1'b0;
    logic [4:0] rd = '0, rs1 = '0, rs2 = '0;

    logic        pcw1, ifw1, bub1, fl1, frz1;
    logic        pcw2, ifw2, bub2, fl2, frz2;
    logic        pcw3, ifw3, bub3, fl3, frz3;
    logic [15:0] c1, c3;
    logic [2:0]  c2;

    always #5 clk = ~clk;

    hazard_stall_controller #(.REG_AW(5), .LOAD_USE_STALLS(1), .CNT_W(16)) dut1 (
        .clk(clk), .rst_n(rst_n), .id_ex_mem_read(mr), .id_ex_rd(rd), .if_id_rs1(rs1),
        .if_id_rs2(rs2), .branch_taken(br), .mem_req(mreq), .mem_ready(mrdy),
        .pc_write(pcw1), .if_id_write(ifw1), .id_ex_bubble(bub1), .if_id_flush(fl1),
        .pipe_freeze(frz1), .stall_cnt(c1));

    hazard_stall_controller #(.REG_AW(5), .LOAD_USE_STALLS(1), .CNT_W(3)) dut2 (
        .clk(clk), .rst_n(rst_n), .id_ex_mem_read(mr), .id_ex_rd(rd), .if_id_rs1(rs1),
        .if_id_rs2(rs2), .branch_taken(br), .mem_req(mreq), .mem_ready(mrdy),
        .pc_write(pcw2), .if_id_write(ifw2), .id_ex_bubble(bub2), .if_id_flush(fl2),
        .pipe_freeze(frz2), .stall_cnt(c2));

    hazard_stall_controller #(.REG_AW(5), .LOAD_USE_STALLS(3), .CNT_W(16)) dut3 (
        .clk(clk), .rst_n(rst_n), .id_ex_mem_read(mr), .id_ex_rd(rd), .if_id_rs1(rs1),
        .if_id_rs2(rs2), .branch_taken(br), .mem_req(mreq), .mem_ready(mrdy),
        .pc_write(pcw3), .if_id_write(ifw3), .id_ex_bubble(bub3), .if_id_flush(fl3),
        .pipe_freeze(frz3), .stall_cnt(c3));

    typedef struct {
        bit          rst;
        int          sel;
        logic        mr;
        logic [4:0]  rd, rs1, rs2;
        logic        br, mreq, mrdy;
        logic [4:0]  exp_o;
        logic [15:0] exp_c;
    } vec_t;

    typedef struct {
        int          sel;
        int          idx;
        logic [4:0]  exp_o;
        logic [15:0] exp_c;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(bit rst, int sel, logic m, int d, int s1, int s2,
                                logic b, logic rq, logic ry, logic [4:0] o, int c);
        vec_t v;
        v.rst = rst;  v.sel = sel;  v.mr = m;
        v.rd = 5'(d); v.rs1 = 5'(s1); v.rs2 = 5'(s2);
        v.br = b;     v.mreq = rq;  v.mrdy = ry;
        v.exp_o = o;  v.exp_c = 16'(c);
        return v;
    endfunction

    function automatic logic [4:0] get_o(int sel);
        case (sel)
            1:       return {pcw1, ifw1, bub1, fl1, frz1};
            2:       return {pcw2, ifw2, bub2, fl2, frz2};
            default: return {pcw3, ifw3, bub3, fl3, frz3};
        endcase
    endfunction

    function automatic logic [15:0] get_c(int sel);
        case (sel)
            1:       return c1;
            2:       return {13'b0, c2};
            default: return c3;
        endcase
    endfunction

    task automatic chk(input string nm, input int idx, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0h, expected %0h", nm, idx, act, exp);
        end
    endtask

    task automatic drive(input logic m, input int d, input int s1, input int s2,
                         input logic b, input logic rq, input logic ry);
        mr = m; rd = 5'(d); rs1 = 5'(s1); rs2 = 5'(s2); br = b; mreq = rq; mrdy = ry;
    endtask

    task automatic push(input int sel, input int idx, input logic [4:0] o, input int c);
        exp_t e;
        e.sel = sel; e.idx = idx; e.exp_o = o; e.exp_c = 16'(c);
        sb.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL scoreboard: no expected entry, got 0 expected 1");
        end else begin
            e = sb.pop_front();
            chk("outputs", e.idx, {11'b0, get_o(e.sel)}, {11'b0, e.exp_o});
            chk("stall_cnt", e.idx, get_c(e.sel), e.exp_c);
        end
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic apply(input vec_t v, input int idx);
        if (v.rst) do_reset();
        drive(v.mr, int'(v.rd), int'(v.rs1), int'(v.rs2), v.br, v.mreq, v.mrdy);
        push(v.sel, idx, v.exp_o, int'(v.exp_c));
        @(negedge clk);
        pop_check();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // N=1: detection, x0 exclusion, priorities
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, NORM,  0));
        tbl.push_back(mk(0, 1, 1, 5, 5, 0, 0, 0, 0, STALL, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, NORM,  1));
        tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, 0, NORM,  1));
        tbl.push_back(mk(0, 1, 0, 7, 0, 7, 0, 0, 0, NORM,  1));
        tbl.push_back(mk(0, 1, 1, 9, 3, 9, 0, 0, 0, STALL, 1));
        tbl.push_back(mk(0, 1, 1, 9, 4, 6, 0, 0, 0, NORM,  2));
        tbl.push_back(mk(0, 1, 1, 5, 5, 0, 1, 0, 0, FLUSH, 2));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, NORM,  2));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1, 1, NORM,  2));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1, 0, FRZ,   2));
        tbl.push_back(mk(0, 1, 1, 5, 5, 0, 1, 1, 0, FRZ,   3));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, NORM,  4));
        // N=3: three-cycle penalty, hazard ignored while stalling
        tbl.push_back(mk(1, 3, 1, 5, 5, 0, 0, 0, 0, STALL, 0));
        tbl.push_back(mk(0, 3, 0, 0, 0, 0, 0, 0, 0, STALL, 1));
        tbl.push_back(mk(0, 3, 0, 0, 0, 0, 0, 0, 0, STALL, 2));
        tbl.push_back(mk(0, 3, 0, 0, 0, 0, 0, 0, 0, NORM,  3));
        tbl.push_back(mk(0, 3, 1, 5, 5, 0, 0, 0, 0, STALL, 3));
        tbl.push_back(mk(0, 3, 1, 5, 5, 0, 0, 0, 0, STALL, 4));
        tbl.push_back(mk(0, 3, 1, 5, 5, 0, 0, 0, 0, STALL, 5));
        tbl.push_back(mk(0, 3, 0, 0, 0, 0, 0, 0, 0, NORM,  6));
        // N=3: branch on second stall cycle, then hazard together with branch
        tbl.push_back(mk(0, 3, 1, 5, 5, 0, 0, 0, 0, STALL, 6));
        tbl.push_back(mk(0, 3, 0, 0, 0, 0, 1, 0, 0, FLUSH, 7));
        tbl.push_back(mk(0, 3, 0, 0, 0, 0, 0, 0, 0, NORM,  7));
        tbl.push_back(mk(0, 3, 0, 0, 0, 0, 0, 0, 0, NORM,  7));
        tbl.push_back(mk(0, 3, 1, 5, 5, 0, 1, 0, 0, FLUSH, 7));
        tbl.push_back(mk(0, 3, 0, 0, 0, 0, 0, 0, 0, NORM,  7));
        // N=3: four-cycle memory freeze from stall cycle 2
        tbl.push_back(mk(1, 3, 1, 5, 5, 0, 0, 0, 0, STALL, 0));
        for (int i = 1; i <= 4; i++)
            tbl.push_back(mk(0, 3, 0, 0, 0, 0, 0, 1, 0, FRZ, i));
        tbl.push_back(mk(0, 3, 0, 0, 0, 0, 0, 0, 0, STALL, 5));
        tbl.push_back(mk(0, 3, 0, 0, 0, 0, 0, 0, 0, STALL, 6));
        tbl.push_back(mk(0, 3, 0, 0, 0, 0, 0, 0, 0, NORM,  7));
        tbl.push_back(mk(0, 3, 0, 0, 0, 0, 0, 0, 0, NORM,  7));
        // 3-bit counter: ten stall cycles saturate at 7
        for (int i = 0; i < 10; i++)
            tbl.push_back(mk(i == 0, 2, 1, 5, 5, 0, 0, 0, 0, STALL, (i > 7) ? 7 : i));
        tbl.push_back(mk(0, 2, 0, 0, 0, 0, 0, 0, 0, NORM, 7));
        tbl.push_back(mk(0, 2, 0, 0, 0, 0, 0, 0, 0, NORM, 7));

        do_reset();
        for (int i = 0; i < tbl.size(); i++)
            apply(tbl[i], i);

        // Asynchronous reset in the middle of an N=3 load stall
        apply(mk(1, 3, 1, 5, 5, 0, 0, 0, 0, STALL, 0), 100);
        apply(mk(0, 3, 0, 0, 0, 0, 0, 0, 0, STALL, 1), 101);
        drive(1, 5, 5, 0, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        push(3, 102, NORM, 0);
        pop_check();
        @(posedge clk);
        #1;
        push(3, 103, NORM, 0);
        pop_check();
        rst_n = 1'b1;
        apply(mk(0, 3, 0, 0, 0, 0, 0, 0, 0, NORM,  0), 104);
        apply(mk(0, 3, 1, 5, 5, 0, 0, 0, 0, STALL, 0), 105);
        apply(mk(0, 3, 0, 0, 0, 0, 0, 0, 0, STALL, 1), 106);

        if (sb.size() != 0) begin
            checks++; errors++;
            $display("FAIL scoreboard_drain: got %0d entries, expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
